// File: rtl/multi_operand_adder_pipe_if.sv
// Operand/result handshake bundle for multi_operand_adder_pipe.
// The master drives the operand sets, and the slave (the adder) returns the sums.
interface multi_operand_adder_pipe_if #(
  parameter int WIDTH  = 6,
  parameter int NUM_IN = 4
);
  localparam int SUM_W = WIDTH + $clog2(NUM_IN);

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic                      cin;
  logic                      out_valid;
  logic                      out_ready;
  logic [SUM_W-1:0]          out_sum;

  modport master (
    output in_valid, in_data, cin, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, cin, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined binary adder tree: NUM_IN unsigned operands plus carry-in, one register per level.
// Optional running accumulator of the output sums is enabled with macro MOA_ACCUM_EN.
module multi_operand_adder_pipe #(
  parameter int WIDTH  = 6,
  parameter int NUM_IN = 4,
  parameter int ACC_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  multi_operand_adder_pipe_if.slave   io
`ifdef MOA_ACCUM_EN
  ,
  input  logic                        acc_clr,
  output logic [ACC_W-1:0]            acc_sum,
  output logic                        acc_ovf
`endif
);
  localparam int LG    = $clog2(NUM_IN);
  localparam int SUM_W = WIDTH + LG;

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("multi_operand_adder_pipe: WIDTH must be in 2..32");
  end
  if ((NUM_IN < 2) || (NUM_IN > 16) || ((1 << LG) != NUM_IN)) begin : g_bad_num_in
    $error("multi_operand_adder_pipe: NUM_IN must be a power of two in 2..16");
  end
  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("multi_operand_adder_pipe: ACC_W must be at least WIDTH+log2(NUM_IN)");
  end

  // The whole tree moves together; a stalled output freezes every level.
  logic advance;
  assign advance     = !io.out_valid || io.out_ready;
  assign io.in_ready = advance;

  genvar l, j;
  for (l = 1; l <= LG; l = l + 1) begin : g_lvl
    localparam int LW = WIDTH + l;
    localparam int NN = NUM_IN >> l;

    logic [LW-1:0] nxt   [NN];
    logic [LW-1:0] sum_p [NN];
    logic          prv_vld;
    logic          vld_p;

    if (l == 1) begin : g_leaf
      assign prv_vld = io.in_valid;
      for (j = 0; j < NN; j = j + 1) begin : g_pair
        assign nxt[j] = LW'(io.in_data[(2*j)*WIDTH +: WIDTH])
                      + LW'(io.in_data[(2*j+1)*WIDTH +: WIDTH])
                      + ((j == 0) ? LW'(io.cin) : LW'(0));
      end
    end else begin : g_node
      assign prv_vld = g_lvl[l-1].vld_p;
      for (j = 0; j < NN; j = j + 1) begin : g_pair
        assign nxt[j] = LW'(g_lvl[l-1].sum_p[2*j]) + LW'(g_lvl[l-1].sum_p[2*j+1]);
      end
    end

    // Level l register boundary: each node is one bit wider than its inputs, so nothing truncates.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= 1'b0;
        for (int k = 0; k < NN; k++) sum_p[k] <= '0;
      end else if (advance) begin
        vld_p <= prv_vld;
        sum_p <= nxt;
      end
    end
  end

  assign io.out_valid = g_lvl[LG].vld_p;
  assign io.out_sum   = g_lvl[LG].sum_p[0];

`ifdef MOA_ACCUM_EN
  logic             out_xfer;
  logic [ACC_W:0]   acc_nxt;

  assign out_xfer = io.out_valid && io.out_ready;
  assign acc_nxt  = {1'b0, acc_sum} + (ACC_W+1)'(io.out_sum);

  // A clear that coincides with a transfer restarts the total at that sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum <= '0;
      acc_ovf <= 1'b0;
    end else if (acc_clr) begin
      acc_sum <= out_xfer ? ACC_W'(io.out_sum) : '0;
      acc_ovf <= 1'b0;
    end else if (out_xfer) begin
      acc_sum <= acc_nxt[ACC_W-1:0];
      if (acc_nxt[ACC_W]) acc_ovf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed bench for multi_operand_adder_pipe: default 6x4 instance plus an 8x16 instance.
// Accumulator checks are compiled in when MOA_ACCUM_EN is defined.
module tb_multi_operand_adder_pipe;
  localparam int W  = 6;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int W2 = 8;
  localparam int N2 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_operand_adder_pipe_if #(.WIDTH(W),  .NUM_IN(N))  io  ();
  multi_operand_adder_pipe_if #(.WIDTH(W2), .NUM_IN(N2)) io2 ();

`ifdef MOA_ACCUM_EN
  logic          acc_clr;
  logic [AW-1:0] acc_sum;
  logic          acc_ovf;
  logic          acc_clr2;
  logic [15:0]   acc_sum2;
  logic          acc_ovf2;
`endif

  multi_operand_adder_pipe #(.WIDTH(W), .NUM_IN(N), .ACC_W(AW)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .io      (io.slave)
`ifdef MOA_ACCUM_EN
    ,
    .acc_clr (acc_clr),
    .acc_sum (acc_sum),
    .acc_ovf (acc_ovf)
`endif
  );

  multi_operand_adder_pipe #(.WIDTH(W2), .NUM_IN(N2), .ACC_W(16)) u_big (
    .clk     (clk),
    .rst     (rst),
    .io      (io2.slave)
`ifdef MOA_ACCUM_EN
    ,
    .acc_clr (acc_clr2),
    .acc_sum (acc_sum2),
    .acc_ovf (acc_ovf2)
`endif
  );

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int exp_q[$];

  // Hand-computed back-to-back vectors: operands 0..3, carry-in, expected sum.
  int vop  [10][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{1,2,3,4}, '{63,0,0,0}, '{10,20,30,40},
                       '{5,17,33,62}, '{63,63,63,63}, '{32,32,32,32}, '{7,9,11,13}, '{0,63,0,63}};
  int vcin [10]    = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 0};
  int vexp [10]    = '{0, 1, 10, 64, 101, 117, 252, 129, 41, 126};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic c, input int e);
    io.in_data  = d;
    io.cin      = c;
    io.in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every output transfer of the default instance must match the next queued sum.
  always @(negedge clk) begin
    if (!rst && io.out_valid && io.out_ready) begin
      rx_cnt++;
      if (exp_q.size() == 0) chk("sb_extra", io.out_valid, 1'b0);
      else                   chk("sb_sum", io.out_sum, exp_q.pop_front());
    end
  end

  initial begin
    int base;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.cin       = 1'b0;
    io.out_ready = 1'b1;
    io2.in_valid = 1'b0;
    io2.in_data  = '0;
    io2.cin      = 1'b0;
    io2.out_ready = 1'b1;
`ifdef MOA_ACCUM_EN
    acc_clr  = 1'b0;
    acc_clr2 = 1'b0;
`endif

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_sum",   io.out_sum,   0);
    chk("rst_in_ready",  io.in_ready,  1);
    chk("rst_big_valid", io2.out_valid, 0);
`ifdef MOA_ACCUM_EN
    chk("rst_acc_sum", acc_sum, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
`endif
    step();
    step();
    rst = 1'b0;

    // All-max operands with carry-in: result on cycle 2
    send(pack4(63,63,63,63), 1'b1, 253);
    chk("t1_in_ready", io.in_ready, 1);
    step();
    io.in_valid = 1'b0;
    chk("t1_lat1", io.out_valid, 0);
    step();
    chk("t1_valid", io.out_valid, 1);
    chk("t1_sum",   io.out_sum,   253);
    step();

    // Ten back-to-back sets, no gaps at the output
    base = rx_cnt;
    for (int k = 0; k <= 12; k++) begin
      if (k < 10) send(pack4(vop[k][0], vop[k][1], vop[k][2], vop[k][3]), vcin[k][0], vexp[k]);
      else        io.in_valid = 1'b0;
      step();
      if ((k + 1 >= 2) && (k + 1 <= 11)) chk("b2b_valid", io.out_valid, 1);
      else if (k + 1 >= 12)              chk("b2b_drained", io.out_valid, 0);
    end
    chk("b2b_count", rx_cnt - base, 10);

    // Output stall for five cycles with results pending
    base = rx_cnt;
    io.out_ready = 1'b0;
    send(pack4(1,1,1,1), 1'b0, 4);
    step();
    send(pack4(60,50,40,30), 1'b1, 181);
    step();
    send(pack4(2,4,8,16), 1'b1, 31);
    for (int s = 0; s < 5; s++) begin
      chk("stall_in_ready",  io.in_ready,  0);
      chk("stall_out_valid", io.out_valid, 1);
      chk("stall_out_sum",   io.out_sum,   4);
      step();
    end
    io.out_ready = 1'b1;
    step();
    io.in_valid = 1'b0;
    for (int s = 0; s < 4; s++) step();
    chk("stall_count", rx_cnt - base, 3);
    chk("stall_sb_empty", exp_q.size(), 0);

    // Reset after two acceptances discards both
    io.out_ready = 1'b0;
    io.in_data   = pack4(5,5,5,5);
    io.cin       = 1'b0;
    io.in_valid  = 1'b1;
    step();
    io.in_data   = pack4(9,8,7,6);
    step();
    io.in_valid  = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",    io.out_valid, 0);
    chk("mid_rst_sum",      io.out_sum,   0);
    chk("mid_rst_in_ready", io.in_ready,  1);
    step();
    rst = 1'b0;
    io.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("post_rst_valid", io.out_valid, 0);
    end

    // First acceptance after reset: valid exactly two cycles later
    send(pack4(11,22,33,44), 1'b0, 110);
    step();
    io.in_valid = 1'b0;
    chk("after_rst_lat1", io.out_valid, 0);
    step();
    chk("after_rst_valid", io.out_valid, 1);
    chk("after_rst_sum",   io.out_sum,   110);
    step();

    // 16 x 255 + 1 on the 8-bit, 16-operand instance: four levels
    io2.in_data  = {16{8'hFF}};
    io2.cin      = 1'b1;
    io2.in_valid = 1'b1;
    step();
    io2.in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      chk("big_lat", io2.out_valid, 0);
      step();
    end
    chk("big_valid", io2.out_valid, 1);
    chk("big_sum",   io2.out_sum,   4081);
    step();

`ifdef MOA_ACCUM_EN
    // Accumulator: three 100s wrap an 8-bit total, then clear together with a 7
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("acc_clr_sum", acc_sum, 0);
    chk("acc_clr_ovf", acc_ovf, 0);
    for (int i = 0; i < 3; i++) begin
      send(pack4(25,25,25,25), 1'b0, 100);
      step();
    end
    io.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("acc_wrap_sum", acc_sum, 44);
    chk("acc_wrap_ovf", acc_ovf, 1);
    send(pack4(7,0,0,0), 1'b0, 7);
    step();
    io.in_valid = 1'b0;
    step();
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("acc_load_sum", acc_sum, 7);
    chk("acc_load_ovf", acc_ovf, 0);
    step();
`endif

    chk("sb_final_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_operand_adder_pipe.md
MULTI_OPERAND_ADDER_PIPE -- requirements
Module: multi_operand_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 6: operand width in bits, legal range 2..32.
REQ-002 Parameter NUM_IN, default 4: operand count, a power of two in 2..16; LG = log2(NUM_IN).
REQ-003 Parameter ACC_W, default 16: accumulator width, at least WIDTH+LG; used only with MOA_ACCUM_EN.
REQ-004 Derived SUM_W = WIDTH+LG.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1: the operand set on in_data/cin is valid.
REQ-008 Port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-009 Port in_data, input, NUM_IN*WIDTH: operand k occupies bits [k*WIDTH +: WIDTH], unsigned.
REQ-010 Port cin, input, 1: carry-in added to the sum, travels with in_data.
REQ-011 Port out_valid, output, 1: out_sum holds a result.
REQ-012 Port out_ready, input, 1: the downstream stage accepts out_sum.
REQ-013 Port out_sum, output, SUM_W: unsigned sum of all operands plus cin.

Function
REQ-014 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-015 Internal signal advance = !out_valid || out_ready; every pipeline register, including its valid bit, loads only when advance is 1.
REQ-016 in_ready = advance, combinationally; it does not depend on in_valid.
REQ-017 The block is a binary adder tree of LG levels with one register per level, so latency is LG cycles from input transfer to out_valid with no stall.
REQ-018 Throughput is one operand set per cycle while out_ready is held at 1.
REQ-019 Level 1 pairs operands 2j and 2j+1; cin is added only in pair 0 of level 1.
REQ-020 Each level widens its result by one bit, and no truncation occurs anywhere.
REQ-021 out_sum equals the exact value sum(in_data[k]) + cin; this value always fits in SUM_W bits because NUM_IN*(2^WIDTH-1)+1 < 2^SUM_W.
REQ-022 A stage's valid bit loads the valid bit of the stage before it, and level 1 loads in_valid.
REQ-023 Bubbles are not collapsed: a stall freezes the whole pipeline.
REQ-024 While out_valid is 1 and out_ready is 0, out_sum and out_valid hold stable.
REQ-025 The data registers of invalid stages may load any value, but out_sum is observed only while out_valid is 1.
REQ-026 A simultaneous output transfer and input transfer in the same cycle is legal and loses no data.

Reset
REQ-027 rst asserted forces all valid bits to 0, all data registers to 0, out_sum to 0 and out_valid to 0, immediately and independent of clk.
REQ-028 During reset in_ready is 1, because out_valid is 0.
REQ-029 Reset mid-operation discards all in-flight operand sets, and none of them appears at the output after reset.
REQ-030 The first input transfer after rst deasserts produces out_valid exactly LG cycles later.

Configuration
REQ-031 With macro MOA_ACCUM_EN defined, the block adds input acc_clr (1 bit), output acc_sum (ACC_W bits) and output acc_ovf (1 bit).
REQ-032 With MOA_ACCUM_EN defined, each output transfer sets acc_sum to acc_sum + out_sum, modulo 2^ACC_W, on the same clock edge.
REQ-033 With MOA_ACCUM_EN defined, acc_ovf is sticky: it sets when that addition carries out of ACC_W bits.
REQ-034 With MOA_ACCUM_EN defined, acc_clr=1 synchronously clears acc_sum and acc_ovf.
REQ-035 With MOA_ACCUM_EN defined, acc_clr coinciding with an output transfer loads acc_sum = out_sum and acc_ovf = 0.
REQ-036 With MOA_ACCUM_EN defined, rst clears acc_sum and acc_ovf to 0.
REQ-037 Without MOA_ACCUM_EN, the acc_clr, acc_sum and acc_ovf ports and the accumulator logic are absent, and the pipeline behaviour is unchanged.

Verification
REQ-038 Scenario: defaults, operands 63,63,63,63 with cin=1, out_ready=1 -> out_sum=253 with out_valid on cycle 2 after acceptance.
REQ-039 Scenario: 10 back-to-back sets of random values with out_ready=1 -> 10 consecutive correct results, in order, with no gaps.
REQ-040 Scenario: out_ready=0 for 5 cycles while results are pending -> in_ready=0, out_sum is stable, and after release all results appear with none lost or duplicated.
REQ-041 Scenario: rst asserted one cycle after two acceptances -> out_valid=0 immediately, and no result emerges afterwards.
REQ-042 Scenario: WIDTH=8, NUM_IN=16, all operands 255, cin=1 -> out_sum=4081 after 4 cycles.
REQ-043 Scenario: MOA_ACCUM_EN with ACC_W=8, three results of 100 -> acc_sum=44 and acc_ovf=1; then acc_clr together with a result of 7 -> acc_sum=7 and acc_ovf=0.
